// File: rtl/layer_pkg.sv
// Shared FSM encoding and sizing helpers for the sequential layer MAC.
package layer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    WB    = 2'd3
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Address width that never collapses to zero bits.
  function automatic int addr_w(input int depth);
    return (clog2(depth) > 0) ? clog2(depth) : 1;
  endfunction

  // Accumulator width: full product plus growth for n additions plus a guard bit.
  function automatic int acc_w(input int res, input int n);
    return 2 * res + clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: accumulates x*w over a group, then adds bias, rescales,
// saturates and optionally applies ReLU to produce the neuron output.
module mac_lane
  import layer_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int ACC_W      = 19,
  parameter int FRAC_BITS  = 4,
  parameter int RELU_EN    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         beat_vld,
  input  logic                         beat_first,
  input  logic signed [RESOLUTION-1:0] x,
  input  logic signed [RESOLUTION-1:0] w,
  input  logic signed [RESOLUTION-1:0] bias,
  output logic        [RESOLUTION-1:0] res
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (RESOLUTION - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [2*RESOLUTION-1:0] prod;
  logic signed [ACC_W-1:0]        prod_ext;
  logic signed [ACC_W-1:0]        acc;
  logic signed [SUM_W-1:0]        bias_ext;
  logic signed [SUM_W-1:0]        sum;
  logic signed [SUM_W-1:0]        shifted;

  assign prod     = x * w;
  assign prod_ext = $signed({{(ACC_W - 2*RESOLUTION){prod[2*RESOLUTION-1]}}, prod});
  assign bias_ext = $signed({{(SUM_W - RESOLUTION){bias[RESOLUTION-1]}}, bias});
  assign sum      = $signed({acc[ACC_W-1], acc}) + (bias_ext <<< FRAC_BITS);
  assign shifted  = sum >>> FRAC_BITS;

  // Accumulator: first beat of a group loads the product, later beats add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         acc <= '0;
    else if (beat_vld)  acc <= beat_first ? prod_ext : acc + prod_ext;
  end

  // Output stage: saturate to the data range, then clamp negatives if ReLU.
  always_comb begin
    res = shifted[RESOLUTION-1:0];
    if (shifted > SAT_MAX)      res = SAT_MAX[RESOLUTION-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[RESOLUTION-1:0];
    if (RELU_EN != 0 && res[RESOLUTION-1]) res = '0;
  end

endmodule

// File: rtl/layer_mac_seq.sv
// Sequential fully-connected layer: PAR lanes sweep the input vector once
// per neuron group, then write the group's outputs into zed.
module layer_mac_seq
  import layer_pkg::*;
#(
  parameter int NUMBER_NEURON   = 30,
  parameter int INPUT_DATA_SIZE = 784,
  parameter int RESOLUTION      = 8,
  parameter int PAR             = 10,
  parameter int FRAC_BITS       = 4,
  parameter int RELU_EN         = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic [addr_w(INPUT_DATA_SIZE)-1:0]       x_addr,
  input  logic [RESOLUTION-1:0]                    x_rdata,
  output logic [addr_w(INPUT_DATA_SIZE*NUMBER_NEURON/PAR)-1:0] w_addr,
  input  logic [RESOLUTION*PAR-1:0]                w_rdata,
  output logic                                     rd_en,
  input  logic [RESOLUTION*NUMBER_NEURON-1:0]      biases,
  output logic [RESOLUTION*NUMBER_NEURON-1:0]      zed
);

  localparam int G     = NUMBER_NEURON / PAR;
  localparam int XA_W  = addr_w(INPUT_DATA_SIZE);
  localparam int WA_W  = addr_w(INPUT_DATA_SIZE * NUMBER_NEURON / PAR);
  localparam int GC_W  = addr_w(G);
  localparam int ACC_W = acc_w(RESOLUTION, INPUT_DATA_SIZE);

  state_t                          state, state_nx;
  logic [XA_W-1:0]                 j_q;
  logic [WA_W-1:0]                 w_q;
  logic [GC_W-1:0]                 g_q;
  logic                            done_q;
  logic                            last_j, last_grp;
  logic [1:0]                      vld_pipe;
  logic                            first_q;
  logic [PAR-1:0][RESOLUTION-1:0]  bias_sel;
  logic [PAR-1:0][RESOLUTION-1:0]  lane_res;
  logic [RESOLUTION*NUMBER_NEURON-1:0] zed_q;

  assign last_j   = (j_q == XA_W'(INPUT_DATA_SIZE - 1));
  assign last_grp = (g_q == GC_W'(G - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and read-enable decode.
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        rd_en = 1'b1;
        if (last_j) state_nx = DRAIN;
      end
      DRAIN: state_nx = WB;
      WB:    state_nx = last_grp ? IDLE : RUN;
      default: state_nx = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = done_q;
  assign x_addr = rd_en ? j_q : '0;
  assign w_addr = rd_en ? w_q : '0;
  assign vld_pipe[0] = rd_en;

  // Sweep counters, read-return tracking and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j_q         <= '0;
      w_q         <= '0;
      g_q         <= '0;
      done_q      <= 1'b0;
      vld_pipe[1] <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      done_q      <= (state == WB) && last_grp;
      vld_pipe[1] <= vld_pipe[0];
      first_q     <= rd_en && (j_q == '0);
      case (state)
        IDLE: begin
          j_q <= '0;
          w_q <= '0;
          g_q <= '0;
        end
        RUN: begin
          j_q <= last_j ? '0 : j_q + 1'b1;
          w_q <= w_q + 1'b1;
        end
        WB: g_q <= last_grp ? '0 : g_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Bias for each lane comes from the neuron it serves in the current group.
  always_comb begin
    bias_sel = '0;
    for (int k = 0; k < PAR; k++)
      bias_sel[k] = biases[(int'(g_q) * PAR + k) * RESOLUTION +: RESOLUTION];
  end

  for (genvar k = 0; k < PAR; k++) begin : g_lane
    mac_lane #(
      .RESOLUTION (RESOLUTION),
      .ACC_W      (ACC_W),
      .FRAC_BITS  (FRAC_BITS),
      .RELU_EN    (RELU_EN)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .beat_vld   (vld_pipe[1]),
      .beat_first (first_q),
      .x          (x_rdata),
      .w          (w_rdata[k*RESOLUTION +: RESOLUTION]),
      .bias       (bias_sel[k]),
      .res        (lane_res[k])
    );
  end

  // Output register: only the current group's slices change, and only in WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) zed_q <= '0;
    else if (state == WB)
      for (int k = 0; k < PAR; k++)
        zed_q[(int'(g_q) * PAR + k) * RESOLUTION +: RESOLUTION] <= lane_res[k];
  end

  assign zed = zed_q;

endmodule
